// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer.
// Opcodes, ALU encodings, sequencer states and instruction classes.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_RST, T0, T1, T2, T3,
    T4, T5, T6, T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU, CL_IMM, CL_LD, CL_ST, CL_BR,
    CL_JR, CL_IN, CL_OUT, CL_NOP, CL_HALT
  } cls_e;

  typedef struct packed {
    logic       PCout;
    logic       Zlowout;
    logic       MDRout;
    logic       InPortout;
    logic       Cout;
    logic       PCin;
    logic       MARin;
    logic       MDRin;
    logic       IRin;
    logic       Yin;
    logic       Zin;
    logic       CONin;
    logic       OutPortin;
    logic       IncPC;
    logic       MD_Read;
    logic       ReadRAM;
    logic       WriteRAM;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       Rin;
    logic       Rout;
    logic       BAout;
    logic [4:0] alu_op;
  } strobe_t;

endpackage

// File: rtl/control_unit_if.sv
// Strobe bundle from the control sequencer to the datapath.
// master drives the strobes, slave (datapath) consumes them.
interface control_unit_if;
  logic       PCout, Zlowout, MDRout;
  logic       InPortout, Cout;
  logic       PCin, MARin, MDRin, IRin;
  logic       Yin, Zin, CONin, OutPortin;
  logic       IncPC;
  logic       MD_Read, ReadRAM, WriteRAM;
  logic       Gra, Grb, Grc;
  logic       Rin, Rout, BAout;
  logic [4:0] alu_op;
  logic       Run;

  modport master (
    output PCout, Zlowout, MDRout,
    output InPortout, Cout,
    output PCin, MARin, MDRin, IRin,
    output Yin, Zin, CONin, OutPortin,
    output IncPC,
    output MD_Read, ReadRAM, WriteRAM,
    output Gra, Grb, Grc,
    output Rin, Rout, BAout,
    output alu_op, Run
  );

  modport slave (
    input PCout, Zlowout, MDRout,
    input InPortout, Cout,
    input PCin, MARin, MDRin, IRin,
    input Yin, Zin, CONin, OutPortin,
    input IncPC,
    input MD_Read, ReadRAM, WriteRAM,
    input Gra, Grb, Grc,
    input Rin, Rout, BAout,
    input alu_op, Run
  );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode to instruction class and index of the final T-step.
// Undefined opcodes fall into the nop class.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] op_i,
  output cls_e           cls_o,
  output logic [2:0]     last_o
);

  always_comb begin
    cls_o = CL_NOP;
    unique case (op_i)
      OP_ADD, OP_SUB,
      OP_AND, OP_OR:   cls_o = CL_ALU;
      OP_ADDI, OP_LDI: cls_o = CL_IMM;
      OP_LD:           cls_o = CL_LD;
      OP_ST:           cls_o = CL_ST;
      OP_BR:           cls_o = CL_BR;
      OP_JR:           cls_o = CL_JR;
      OP_IN:           cls_o = CL_IN;
      OP_OUT:          cls_o = CL_OUT;
      OP_HALT:         cls_o = CL_HALT;
      default:         cls_o = CL_NOP;
    endcase
  end

  always_comb begin
    last_o = 3'd3;
    unique case (cls_o)
      CL_ALU, CL_IMM: last_o = 3'd5;
      CL_LD, CL_ST:   last_o = 3'd7;
      CL_BR:          last_o = 3'd6;
      default:        last_o = 3'd3;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired T-step sequencer driving every datapath strobe.
// Fetch is shared; execute steps depend on the decoded class.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        CONFFOut,
  input  logic        Stop,
  control_unit_if.master bus
);

  state_e         state_q, state_d;
  cls_e           cls;
  logic [2:0]     last;
  logic [2:0]     step;
  logic [OPW-1:0] op;
  logic           unused_ir;
  strobe_t        s;

  assign op        = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];
  assign step      = 3'(state_q - T0);

  ctrl_decode #(.OPW(OPW)) u_dec (
    .op_i   (op),
    .cls_o  (cls),
    .last_o (last)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_RST;
    else      state_q <= state_d;
  end

  // Stop only matters on the edge that closes an instruction.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:  state_d = T0;
      S_HALT: state_d = S_HALT;
      T0:     state_d = T1;
      T1:     state_d = T2;
      T2:     state_d = T3;
      default: begin
        if (step == last)
          state_d = (cls == CL_HALT || Stop) ? S_HALT : T0;
        else
          state_d = state_e'(state_q + 4'd1);
      end
    endcase
  end

  always_comb begin
    s = '0;
    unique case (state_q)
      T0: begin
        s.PCout = 1'b1; s.MARin = 1'b1;
        s.IncPC = 1'b1; s.Zin   = 1'b1;
      end
      T1: begin
        s.Zlowout = 1'b1; s.PCin    = 1'b1;
        s.ReadRAM = 1'b1; s.MD_Read = 1'b1;
        s.MDRin   = 1'b1;
      end
      T2: begin
        s.MDRout = 1'b1; s.IRin = 1'b1;
      end
      T3: begin
        case (cls)
          CL_ALU: begin
            s.Grb = 1'b1; s.Rout = 1'b1; s.Yin = 1'b1;
          end
          CL_IMM, CL_LD, CL_ST: begin
            s.Grb = 1'b1; s.BAout = 1'b1; s.Yin = 1'b1;
          end
          CL_BR: begin
            s.Gra = 1'b1; s.Rout = 1'b1; s.CONin = 1'b1;
          end
          CL_JR: begin
            s.Gra = 1'b1; s.Rout = 1'b1; s.PCin = 1'b1;
          end
          CL_IN: begin
            s.InPortout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1;
          end
          CL_OUT: begin
            s.Gra = 1'b1; s.Rout = 1'b1; s.OutPortin = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          CL_ALU: begin
            s.Grc = 1'b1; s.Rout = 1'b1; s.Zin = 1'b1;
            s.alu_op = op;
          end
          CL_IMM, CL_LD, CL_ST: begin
            s.Cout = 1'b1; s.Zin = 1'b1; s.alu_op = ALU_ADD;
          end
          CL_BR: begin
            s.PCout = 1'b1; s.Yin = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CL_ALU, CL_IMM: begin
            s.Zlowout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1;
          end
          CL_LD, CL_ST: begin
            s.Zlowout = 1'b1; s.MARin = 1'b1;
          end
          CL_BR: begin
            s.Cout = 1'b1; s.Zin = 1'b1; s.alu_op = ALU_ADD;
          end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CL_LD: begin
            s.ReadRAM = 1'b1; s.MD_Read = 1'b1; s.MDRin = 1'b1;
          end
          CL_ST: begin
            s.Gra = 1'b1; s.Rout = 1'b1; s.MDRin = 1'b1;
          end
          CL_BR: begin
            s.Zlowout = CONFFOut; s.PCin = CONFFOut;
          end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          CL_LD: begin
            s.MDRout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1;
          end
          CL_ST:   s.WriteRAM = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.PCout     = s.PCout;
  assign bus.Zlowout   = s.Zlowout;
  assign bus.MDRout    = s.MDRout;
  assign bus.InPortout = s.InPortout;
  assign bus.Cout      = s.Cout;
  assign bus.PCin      = s.PCin;
  assign bus.MARin     = s.MARin;
  assign bus.MDRin     = s.MDRin;
  assign bus.IRin      = s.IRin;
  assign bus.Yin       = s.Yin;
  assign bus.Zin       = s.Zin;
  assign bus.CONin     = s.CONin;
  assign bus.OutPortin = s.OutPortin;
  assign bus.IncPC     = s.IncPC;
  assign bus.MD_Read   = s.MD_Read;
  assign bus.ReadRAM   = s.ReadRAM;
  assign bus.WriteRAM  = s.WriteRAM;
  assign bus.Gra       = s.Gra;
  assign bus.Grb       = s.Grb;
  assign bus.Grc       = s.Grc;
  assign bus.Rin       = s.Rin;
  assign bus.Rout      = s.Rout;
  assign bus.BAout     = s.BAout;
  assign bus.alu_op    = s.alu_op;
  assign bus.Run       = (state_q != S_RST) && (state_q != S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle model compare
// plus literal checks of key T-steps, stop, halt and reset.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] ir = '0;
  logic        CONFFOut = 1'b0;
  logic        Stop = 1'b0;

  control_unit_if cb();

  control_unit #(.OPW(5)) dut (
    .clk      (clk),
    .clr      (clr),
    .ir       (ir),
    .CONFFOut (CONFFOut),
    .Stop     (Stop),
    .bus      (cb.master)
  );

  always #5 clk = ~clk;

  localparam int BA = 0, RO = 1, RI = 2, GC = 3, GB = 4, GA = 5;
  localparam int WR = 6, RR = 7, MR = 8, IP = 9, OPI = 10;
  localparam int CI = 11, ZI = 12, YI = 13, II = 14, MDI = 15;
  localparam int MAI = 16, PCI = 17, CO = 18, IPO = 19;
  localparam int MDO = 20, ZLO = 21, PCO = 22, RUN = 23;

  localparam logic [31:0] W_ADD  = 32'h18908000;
  localparam logic [31:0] W_ADDI = 32'h60000000;
  localparam logic [31:0] W_LDI  = 32'h08000000;
  localparam logic [31:0] W_LD   = 32'h00000000;
  localparam logic [31:0] W_ST   = 32'h10000000;
  localparam logic [31:0] W_BR   = 32'h90000000;
  localparam logic [31:0] W_JR   = 32'h98000000;
  localparam logic [31:0] W_IN   = 32'hB0000000;
  localparam logic [31:0] W_OUT  = 32'hB8000000;
  localparam logic [31:0] W_NOP  = 32'hD0000000;
  localparam logic [31:0] W_UND  = 32'h40000000;
  localparam logic [31:0] W_HALT = 32'hD8000000;

  logic [28:0] obs;
  assign obs = {cb.alu_op, cb.Run, cb.PCout, cb.Zlowout,
                cb.MDRout, cb.InPortout, cb.Cout, cb.PCin,
                cb.MARin, cb.MDRin, cb.IRin, cb.Yin, cb.Zin,
                cb.CONin, cb.OutPortin, cb.IncPC, cb.MD_Read,
                cb.ReadRAM, cb.WriteRAM, cb.Gra, cb.Grb,
                cb.Grc, cb.Rin, cb.Rout, cb.BAout};

  int n_cmp = 0;
  int n_bad = 0;
  logic [28:0] cap [0:7];
  logic [28:0] e_cmp;

  function automatic logic [28:0] b(input int i);
    return 29'd1 << i;
  endfunction

  function automatic logic [28:0] al(input logic [4:0] v);
    return {v, 24'd0};
  endfunction

  // Total cycles per instruction, fetch included.
  function automatic int mlen(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd1: return 6;
      5'd0, 5'd2: return 8;
      5'd18: return 7;
      default: return 4;
    endcase
  endfunction

  // mode: 0 reset, 1 running, 2 halted
  function automatic logic [28:0] expv(input int mode, input int step,
                                       input logic [4:0] op,
                                       input logic con);
    logic [28:0] r;
    if (mode != 1) return '0;
    r = b(RUN);
    if (step == 0) return r | b(PCO) | b(MAI) | b(IP) | b(ZI);
    if (step == 1)
      return r | b(ZLO) | b(PCI) | b(RR) | b(MR) | b(MDI);
    if (step == 2) return r | b(MDO) | b(II);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        if (step == 3) r |= b(GB) | b(RO) | b(YI);
        if (step == 4) r |= b(GC) | b(RO) | b(ZI) | al(op);
        if (step == 5) r |= b(ZLO) | b(GA) | b(RI);
      end
      5'd12, 5'd1, 5'd0, 5'd2: begin
        if (step == 3) r |= b(GB) | b(BA) | b(YI);
        if (step == 4) r |= b(CO) | b(ZI) | al(5'd3);
        if (step == 5 && (op == 5'd12 || op == 5'd1))
          r |= b(ZLO) | b(GA) | b(RI);
        if (step == 5 && (op == 5'd0 || op == 5'd2))
          r |= b(ZLO) | b(MAI);
        if (step == 6 && op == 5'd0) r |= b(RR) | b(MR) | b(MDI);
        if (step == 6 && op == 5'd2) r |= b(GA) | b(RO) | b(MDI);
        if (step == 7 && op == 5'd0) r |= b(MDO) | b(GA) | b(RI);
        if (step == 7 && op == 5'd2) r |= b(WR);
      end
      5'd18: begin
        if (step == 3) r |= b(GA) | b(RO) | b(CI);
        if (step == 4) r |= b(PCO) | b(YI);
        if (step == 5) r |= b(CO) | b(ZI) | al(5'd3);
        if (step == 6 && con) r |= b(ZLO) | b(PCI);
      end
      5'd19: r |= b(GA) | b(RO) | b(PCI);
      5'd22: r |= b(IPO) | b(GA) | b(RI);
      5'd23: r |= b(GA) | b(RO) | b(OPI);
      default: ;
    endcase
    return r;
  endfunction

  int m_mode = 0;
  int m_step = 0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_mode <= 0;
      m_step <= 0;
    end else begin
      case (m_mode)
        0: begin
          m_mode <= 1;
          m_step <= 0;
        end
        1: begin
          if (m_step == mlen(ir[31:27]) - 1) begin
            if (ir[31:27] == 5'd27 || Stop) m_mode <= 2;
            m_step <= 0;
          end else begin
            m_step <= m_step + 1;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    e_cmp = expv(m_mode, m_step, ir[31:27], CONFFOut);
    n_cmp++;
    if (obs !== e_cmp) begin
      n_bad++;
      $display("FAIL cycle t=%0t mode=%0d step=%0d got=%h want=%h",
               $time, m_mode, m_step, obs, e_cmp);
    end
  end

  task automatic chk(input string nm, input logic [28:0] got,
                     input logic [28:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Starts in T0; ends 1 time unit after the edge closing the instr.
  task automatic issue(input logic [31:0] w, input logic c,
                       input int stop_at);
    int n;
    n = mlen(w[31:27]);
    ir = w;
    CONFFOut = c;
    for (int k = 0; k < n; k++) begin
      Stop = (k == stop_at);
      #1;
      cap[k] = obs;
      @(posedge clk);
      #1;
    end
    Stop = 1'b0;
  endtask

  logic [28:0] F0;
  logic [31:0] sticky [0:3];

  initial begin
    F0 = b(RUN) | b(PCO) | b(MAI) | b(IP) | b(ZI);
    sticky[0] = W_ADD;
    sticky[1] = W_LD;
    sticky[2] = W_BR;
    sticky[3] = W_NOP;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_zero", obs, '0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("first_T0", obs, F0);

    issue(W_ADD, 1'b0, -1);
    chk("add_T4", cap[4], b(GC) | b(RO) | b(ZI) | b(RUN) | al(5'd3));
    chk("add_T5", cap[5], b(ZLO) | b(GA) | b(RI) | b(RUN));
    chk("add_T0_after6", obs, F0);

    issue(W_ADDI, 1'b0, -1);
    chk("addi_T4", cap[4], b(CO) | b(ZI) | b(RUN) | al(5'd3));
    issue(W_LDI, 1'b0, -1);
    chk("ldi_T3", cap[3], b(GB) | b(BA) | b(YI) | b(RUN));

    issue(W_LD, 1'b0, -1);
    chk("ld_T6", cap[6], b(RR) | b(MR) | b(MDI) | b(RUN));
    chk("ld_T7", cap[7], b(MDO) | b(GA) | b(RI) | b(RUN));

    issue(W_ST, 1'b0, -1);
    chk("st_T6", cap[6], b(GA) | b(RO) | b(MDI) | b(RUN));
    chk("st_T7", cap[7], b(WR) | b(RUN));

    issue(W_BR, 1'b1, -1);
    chk("br_taken_T6", cap[6], b(ZLO) | b(PCI) | b(RUN));
    chk("br_taken_T0", obs, F0);
    issue(W_BR, 1'b0, -1);
    chk("br_not_T6", cap[6], b(RUN));
    chk("br_not_T0", obs, F0);

    issue(W_JR, 1'b0, -1);
    chk("jr_T3", cap[3], b(GA) | b(RO) | b(PCI) | b(RUN));
    issue(W_IN, 1'b0, -1);
    chk("in_T3", cap[3], b(IPO) | b(GA) | b(RI) | b(RUN));
    issue(W_OUT, 1'b0, -1);
    chk("out_T3", cap[3], b(GA) | b(RO) | b(OPI) | b(RUN));
    issue(W_NOP, 1'b0, -1);
    chk("nop_T3", cap[3], b(RUN));
    issue(W_UND, 1'b0, -1);
    chk("undef_T3", cap[3], b(RUN));
    chk("undef_T0", obs, F0);

    issue(W_ADD, 1'b0, 4);
    chk("stop_pulse_T0", obs, F0);
    issue(W_ADD, 1'b0, 5);
    chk("stop_halt", obs, '0);
    for (int i = 0; i < 20; i++) begin
      ir = sticky[i % 4];
      @(posedge clk);
      #1;
      chk("stop_halt_hold", obs, '0);
    end

    clr = 1'b0;
    #1;
    chk("reset_from_halt", obs, '0);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_T0", obs, F0);

    ir = W_ST;
    repeat (6) @(posedge clk);
    #1;
    chk("st_T6_pre_clr", obs, b(GA) | b(RO) | b(MDI) | b(RUN));
    #1;
    clr = 1'b0;
    #1;
    chk("clr_abort", obs, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("clr_no_write", obs, '0);
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_release_T0", obs, F0);

    issue(W_HALT, 1'b0, -1);
    chk("halt_T3", cap[3], b(RUN));
    chk("halt_run_low", obs, '0);
    for (int i = 0; i < 4; i++) begin
      ir = sticky[i];
      @(posedge clk);
      #1;
      chk("halt_sticky", obs, '0);
    end

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the Phase 3 CPU, located directly upstream of `datapath`. It samples the instruction register and the CON flip-flop. Each cycle it drives every datapath strobe: register select/enable, bus drivers, memory and port strobes, and ALU op. Each instruction runs as a fixed sequence of one-cycle T-steps. The block halts on the `halt` opcode or on an external `Stop` request.

## Interface
Parameters:
- `OPW`, 5, opcode width (opcode = `ir[31:27]`)

Ports:
- `clk`  in  1  system clock, rising-edge
- `clr`  in  1  asynchronous, active-low reset
- `ir`  in  32  instruction register contents from datapath
- `CONFFOut`  in  1  branch condition flip-flop output
- `Stop`  in  1  external halt request, level
- `PCout, Zlowout, MDRout, InPortout, Cout`  out  1 each  bus-driver enables
- `PCin, MARin, MDRin, IRin, Yin, Zin, CONin, OutPortin`  out  1 each  register load enables
- `IncPC`  out  1  ALU forces PC+1 into Z
- `MD_Read, ReadRAM, WriteRAM`  out  1 each  MDR source select; memory read/write strobes
- `Gra, Grb, Grc, Rin, Rout, BAout`  out  1 each  register-file select/enable
- `alu_op`  out  5  ALU operation, opcode encoding
- `Run`  out  1  1 while executing, 0 in reset/halt

## Operation
- States: `S_RST`, `T0`…`T7`, `S_HALT`. Outputs are combinational from the state register and the opcode. All strobes not listed for a step are 0. `alu_op` = 0 unless listed.
- Fetch is common to all instructions:
  - T0: `PCout MARin IncPC Zin`
  - T1: `Zlowout PCin ReadRAM MD_Read MDRin`
  - T2: `MDRout IRin`
- Execute steps by opcode class:
  - add/sub/and/or (00011/00100/00101/00110):
    - T3 `Grb Rout Yin`
    - T4 `Grc Rout Zin alu_op=opcode`
    - T5 `Zlowout Gra Rin`
  - addi (01100), ldi (00001):
    - T3 `Grb BAout Yin`
    - T4 `Cout Zin alu_op=ADD`
    - T5 `Zlowout Gra Rin`
  - ld (00000):
    - T3–T4 as addi
    - T5 `Zlowout MARin`
    - T6 `ReadRAM MD_Read MDRin`
    - T7 `MDRout Gra Rin`
  - st (00010):
    - T3–T5 as ld
    - T6 `Gra Rout MDRin` (`MD_Read`=0)
    - T7 `WriteRAM`
  - br (10010):
    - T3 `Gra Rout CONin`
    - T4 `PCout Yin`
    - T5 `Cout Zin alu_op=ADD`
    - T6 `Zlowout PCin` only if `CONFFOut`=1, else no strobes
  - jr (10011): T3 `Gra Rout PCin`
  - in (10110): T3 `InPortout Gra Rin`
  - out (10111): T3 `Gra Rout OutPortin`
  - nop (11010) and any undefined opcode: T3 no strobes
  - halt (11011): T3 → `S_HALT`
- After an instruction's last step the state returns to T0. If `Stop`=1 at that edge, the state goes to `S_HALT` instead.
- `S_HALT` is sticky. All strobes are 0 and `Run`=0. Only `clr` exits it.

## Timing
- While `clr`=0: state is `S_RST`, every output is 0, `Run`=0. Reset is asynchronous; asserting it mid-instruction aborts immediately, including an in-progress T7 write.
- On the first rising edge after `clr` deasserts: `S_RST` → T0 and `Run`=1.
- One T-step per clock. Instruction lengths including fetch:
  - ALU/addi/ldi: 6 cycles
  - ld/st: 8 cycles
  - br: 7 cycles
  - jr/in/out/nop: 4 cycles
- The opcode is sampled from `ir` during T3–T7 only. During T0–T2 `ir` is don't-care, so the IR load at the end of T2 is safe.
- `CONFFOut` is sampled only in T6 of br, three edges after `CONin` in T3.
- `Stop` is sampled only on the edge that ends an instruction. It never truncates an instruction. A pulse on any other cycle is ignored.
- `halt` raised together with `Stop` gives the same result: `S_HALT`.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - opcode constants
  - `ALU_ADD` (= 00011)
  - state enum
  - instruction-class enum: ALU, IMM, LD, ST, BR, JR, IN, OUT, NOP, HALT
- One sub-module, `ctrl_decode`: combinational map from opcode to instruction class and last-step index. It is instantiated once.

## Test plan
- Reset, then `ir`=0x18908000 (add R1,R2,R3):
  - T4 has `Grc Rout Zin alu_op`=00011.
  - T5 has `Gra Rin`.
  - `Run`=1, and the next T0 comes 6 cycles after the first.
- ld (opcode 00000):
  - T6 asserts `ReadRAM MD_Read MDRin`.
  - T7 asserts `MDRout Gra Rin`.
  - st (00010) asserts `WriteRAM` only in T7, with `MD_Read`=0 in T6.
- br (10010):
  - With `CONFFOut`=1, T6 has `Zlowout PCin`.
  - With `CONFFOut`=0, T6 has no strobes.
  - Both cases return to T0 after 7 cycles.
- `Stop` pulsed during T4 of an add: ignored. `Stop` held at the end of the instruction: next state is `S_HALT`, `Run`=0, outputs stay 0 for 20 cycles.
- `clr` asserted during T6 of st:
  - all outputs drop to 0 immediately, with no `WriteRAM` in the following cycles
  - after release, T0 strobes appear on the first edge
- halt (11011): `Run` falls after T3, and the state stays in `S_HALT` across new `ir` values.
